// File: rtl/regfile_bypass_sb.sv
// Register file for the pipelined MIPS datapath.
// It has two combinational read ports, one synchronous writeback port and an
// optional hardwired zero register. Writeback can bypass to the read ports in
// the same cycle. A per-register saturating pending-write counter lets decode
// detect RAW hazards and hold back issue once a destination is saturated.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [PEND_W-1:0] pend [DEPTH];
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;
  logic              issue_fire;
  logic              dest_is_zero;
  logic              wr_hit1;
  logic              wr_hit2;

  // Issue to the hardwired zero register is always accepted; its counter never moves.
  assign dest_is_zero = (ZERO_REG != 0) && (issue_dest == '0);
  assign issue_ready  = (pend[issue_dest] != PEND_MAX) || dest_is_zero;
  assign issue_fire   = issue_valid && issue_ready;

  // Per-register increment and decrement requests for the pending counters.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inc_vec[i] = issue_fire && (issue_dest == ADDR_W'(i));
      dec_vec[i] = we && (waddr == ADDR_W'(i)) && (pend[i] != '0);
    end
  end

  // Writeback into the register array; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
      regs[waddr] <= wdata;
    end
  end

  // Pending-write counters: a simultaneous issue and writeback cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((ZERO_REG != 0) && (i == 0)) begin
          pend[i] <= '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          pend[i] <= pend[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

  // Read port 1: array value, optionally overridden by a same-cycle writeback.
  always_comb begin
    wr_hit1 = we && (waddr == raddr1);
    rdata1  = regs[raddr1];
    busy1   = (pend[raddr1] != '0);
    if ((BYPASS != 0) && wr_hit1) begin
      rdata1 = wdata;
      busy1  = ((pend[raddr1] - PEND_W'(pend[raddr1] != '0)) != '0);
    end
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
  end

  // Read port 2: identical to port 1 and fully independent of it.
  always_comb begin
    wr_hit2 = we && (waddr == raddr2);
    rdata2  = regs[raddr2];
    busy2   = (pend[raddr2] != '0);
    if ((BYPASS != 0) && wr_hit2) begin
      rdata2 = wdata;
      busy2  = ((pend[raddr2] - PEND_W'(pend[raddr2] != '0)) != '0);
    end
    if ((ZERO_REG != 0) && (raddr2 == '0)) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
  end

endmodule
